// File: rtl/dmem_resp_pkg.sv
// rtl/dmem_resp_pkg.sv - shared types, constants and helpers for the data memory responder
package dmem_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int WAIT_W     = 4;

  // A data access must be word aligned; any low address bit set is an error.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// rtl/data_memory_responder_if.sv - request/response handshake bundle between CPU and data memory
interface data_memory_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_word_array.sv
// rtl/dmem_word_array.sv - word storage with byte-enabled write, registered read and reset clear
module dmem_word_array #(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrEn,
  input  logic [AW-1:0] wrIdx,
  input  logic [31:0]   wrData,
  input  logic [3:0]    wrBe,
  input  logic          rdEn,
  input  logic [AW-1:0] rdIdx,
  output logic [31:0]   rdData
);

  logic [31:0] mem [DEPTH_WORDS];

  // Clear every word during reset; otherwise commit enabled bytes and capture read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
      rdData <= '0;
    end else begin
      if (wrEn) begin
        for (int b = 0; b < 4; b++) begin
          if (wrBe[b]) begin
            mem[wrIdx][8*b +: 8] <= wrData[8*b +: 8];
          end
        end
      end
      if (rdEn) begin
        rdData <= mem[rdIdx];
      end
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - wait-state data memory responder; DMEM_ACCESS_COUNT_EN adds rd_count/wr_count
module data_memory_responder
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  data_memory_responder_if.slave  bus
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [15:0]             rd_count,
  output logic [15:0]             wr_count
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES == 0) ? '0 : WAIT_W'(WAIT_CYCLES - 1);

  dmem_state_t       state, stateNext;
  logic [WAIT_W-1:0] waitCnt;
  logic              capWrite;
  logic [31:0]       capAddr, capWdata;
  logic [3:0]        capBe;
  logic              respErr, respWrite;
  logic [31:0]       rdData;

  logic              accept, doAccess;
  logic              accWrite, accErr;
  logic [31:0]       accAddr, accWdata;
  logic [3:0]        accBe;

  // With zero wait states the access happens on the accept edge, so use the live request.
  always_comb begin
    accWrite = capWrite;
    accAddr  = capAddr;
    accWdata = capWdata;
    accBe    = capBe;
    if (state == IDLE) begin
      accWrite = bus.req_write;
      accAddr  = bus.req_addr;
      accWdata = bus.req_wdata;
      accBe    = bus.req_be;
    end
    accErr = is_misaligned(accAddr) ||
             (accAddr >= 32'(DEPTH_WORDS * WORD_BYTES));
  end

  // Next-state logic and the accept/access strobes.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    doAccess  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            doAccess  = 1'b1;
            stateNext = RESP;
          end else begin
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        if (waitCnt == '0) begin
          doAccess  = 1'b1;
          stateNext = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.req_ready  = (state == IDLE) && !rst;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = (state == RESP) && respErr;
  assign bus.resp_rdata = ((state == RESP) && !respWrite && !respErr) ? rdData : '0;

  // State register, request capture, wait countdown and response flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= '0;
      capWrite  <= 1'b0;
      capAddr   <= '0;
      capWdata  <= '0;
      capBe     <= '0;
      respErr   <= 1'b0;
      respWrite <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) begin
        capWrite <= bus.req_write;
        capAddr  <= bus.req_addr;
        capWdata <= bus.req_wdata;
        capBe    <= bus.req_be;
        waitCnt  <= WAIT_INIT;
      end else if (state == WAIT && waitCnt != '0) begin
        waitCnt <= waitCnt - 1'b1;
      end
      if (doAccess) begin
        respErr   <= accErr;
        respWrite <= accWrite;
      end
    end
  end

  dmem_word_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (doAccess && accWrite && !accErr),
    .wrIdx  (accAddr[AW+1:2]),
    .wrData (accWdata),
    .wrBe   (accBe),
    .rdEn   (doAccess && !accWrite && !accErr),
    .rdIdx  (accAddr[AW+1:2]),
    .rdData (rdData)
  );

`ifdef DMEM_ACCESS_COUNT_EN
  // Count successful reads and writes at the response handshake, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == RESP && bus.resp_ready && !respErr) begin
      if (respWrite) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule
